// File: rtl/mem_arbiter_if.sv
// Purpose: requester-side handshake and memory-side strobes between two masters, the arbiter and mem.
// Latency: none; this is a plain signal bundle.
// Backpressure: masters hold req/we/addr/wdata until their gnt pulse.
interface mem_arbiter_if #(
  parameter int DEPTH = 32,
  parameter int WIDTH = 8
);
  localparam int AW = $clog2(DEPTH);

  logic [1:0]       req;
  logic [1:0]       we;
  logic [AW-1:0]    addr0;
  logic [AW-1:0]    addr1;
  logic [WIDTH-1:0] wdata0;
  logic [WIDTH-1:0] wdata1;
  logic [1:0]       gnt;
  logic [1:0]       rvalid;
  logic [WIDTH-1:0] rdata;
  logic             mem_read;
  logic             mem_write;
  logic [AW-1:0]    mem_addr;
  logic [WIDTH-1:0] mem_data_in;
  logic [WIDTH-1:0] mem_data_out;

  // Requester/memory side: drives requests and memory read data, observes grants and strobes.
  modport master (
    output req, we, addr0, addr1, wdata0, wdata1, mem_data_out,
    input  gnt, rvalid, rdata, mem_read, mem_write, mem_addr, mem_data_in
  );

  // Arbiter side.
  modport slave (
    input  req, we, addr0, addr1, wdata0, wdata1, mem_data_out,
    output gnt, rvalid, rdata, mem_read, mem_write, mem_addr, mem_data_in
  );
endinterface

// File: rtl/mem_arbiter.sv
// Purpose: round-robin arbiter sharing one single-port memory between two masters.
// Latency: write gnt/strobe 1 cycle after req seen in IDLE; read rvalid 3 cycles after.
// Backpressure: requests wait in place (held by master) until the FSM returns to IDLE.
module mem_arbiter #(
  parameter int DEPTH = 32,
  parameter int WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, RWAIT, RDONE} state_t;

  state_t           state;
  state_t           state_nxt;
  logic             prio;
  logic             win;
  logic             load;
  logic             cmd_id;
  logic             cmd_we;
  logic [AW-1:0]    cmd_addr;
  logic [WIDTH-1:0] cmd_wdata;
  logic [WIDTH-1:0] rdata_q;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Winner selection and next-state decode; requests are only looked at in IDLE.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    win       = (bus.req == 2'b11) ? prio : bus.req[1];
    case (state)
      IDLE: begin
        if (|bus.req) begin
          load      = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE:   state_nxt = cmd_we ? IDLE : RWAIT;
      RWAIT:   state_nxt = RDONE;
      RDONE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Command capture, priority rotation and read-data capture.
  // Write data is only captured for writes so mem_data_in keeps its last written value across reads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio      <= 1'b0;
      cmd_id    <= 1'b0;
      cmd_we    <= 1'b0;
      cmd_addr  <= '0;
      cmd_wdata <= '0;
      rdata_q   <= '0;
    end else begin
      if (load) begin
        cmd_id   <= win;
        cmd_we   <= bus.we[win];
        cmd_addr <= win ? bus.addr1 : bus.addr0;
        if (bus.we[win]) cmd_wdata <= win ? bus.wdata1 : bus.wdata0;
      end
      if (state == ISSUE) prio <= ~cmd_id;
      if (state == RWAIT) rdata_q <= bus.mem_data_out;
    end
  end

  // Outputs depend only on registered state; the address register only changes when a strobe rises.
  assign bus.gnt         = (state == ISSUE) ? (cmd_id ? 2'b10 : 2'b01) : 2'b00;
  assign bus.rvalid      = (state == RDONE) ? (cmd_id ? 2'b10 : 2'b01) : 2'b00;
  assign bus.rdata       = rdata_q;
  assign bus.mem_write   = (state == ISSUE) &&  cmd_we;
  assign bus.mem_read    = (state == ISSUE) && !cmd_we;
  assign bus.mem_addr    = cmd_addr;
  assign bus.mem_data_in = cmd_wdata;
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester round-robin arbiter that shares the single-port `mem` block (DEPTH×WIDTH, read/write via `mem_intf`) between two independent masters. Each master makes one read or write transaction at a time. The block serialises transactions onto the memory's read/write strobes and returns read data to the requester that issued the read. It sits between the masters and the `mem` instance in `top`, and is clocked by the same `clk`.

## Interface
Parameters:
- DEPTH, 32, memory words; address width AW = $clog2(DEPTH)
- WIDTH, 8, data bits per word

Ports:
- clk  in  1  system clock; all logic on the rising edge
- rst  in  1  reset, asynchronous and active-high
- req[1:0]  in  2  request per master; held until the matching gnt
- we[1:0]  in  2  1 = write, 0 = read; held with req
- addr0, addr1  in  AW each  master addresses; held with req
- wdata0, wdata1  in  WIDTH each  master write data; held with req
- gnt[1:0]  out  2  one-cycle pulse; the command was issued to memory this cycle
- rvalid[1:0]  out  2  one-cycle pulse; rdata is valid for that master
- rdata  out  WIDTH  read data, shared by both masters; qualified by rvalid
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- mem_addr  out  AW  memory address
- mem_data_in  out  WIDTH  memory write data
- mem_data_out  in  WIDTH  memory read data; valid in the cycle after mem_read

## Operation
FSM states: IDLE, ISSUE, RWAIT, RDONE.
- IDLE:
  - If no req, stay in IDLE.
  - Otherwise select the winner:
    - If only one master requests, that master wins.
    - If both request, the master indicated by the priority pointer `prio` wins.
  - Register winner id, we, addr and wdata, then go to ISSUE.
- ISSUE:
  - Drive mem_addr from the registered address.
  - For a write, drive mem_write=1 and mem_data_in from the registered data.
  - For a read, drive mem_read=1.
  - gnt[winner]=1.
  - Set `prio` = ~winner.
  - Next state: write → IDLE; read → RWAIT.
- RWAIT: memory presents data. Capture mem_data_out into the rdata register, then go to RDONE.
- RDONE: rvalid[winner]=1 and rdata holds the captured word. Go to IDLE.
- Each master drops req in the cycle after its gnt, or keeps it high to queue a new transaction.
  - Requests are sampled only in IDLE.
  - req, we, addr and wdata may change after gnt without affecting the transaction in flight.
- The registered command is frozen from IDLE until the FSM returns to IDLE.
- Starvation-free: under continuous contention, grants alternate 0, 1, 0, 1, ...
- Outputs are decoded from registered state only; there is no combinational path from req to any output.

## Timing
Reset values:
- state = IDLE, prio = 0 (master 0 favoured).
- gnt = 0, rvalid = 0, rdata = 0.
- mem_read = 0, mem_write = 0, mem_addr = 0, mem_data_in = 0.

Latency and throughput:
- Write: req seen in IDLE at cycle N; gnt and mem_write in cycle N+1; next arbitration in cycle N+2. Peak rate is one write per 2 cycles.
- Read: req seen at N; gnt and mem_read at N+1; capture at N+2; rvalid at N+3; next arbitration at N+4. Peak rate is one read per 4 cycles.

Strobes and buses:
- mem_read and mem_write are never high together.
- Each strobe is high for exactly one cycle per transaction.
- mem_addr and mem_data_in hold their last value when no strobe is asserted.

Simultaneous events and boundaries:
- req arriving outside IDLE waits; it is not lost.
- Reset asserted mid-transaction (ISSUE, RWAIT or RDONE):
  - Outputs go to reset values immediately.
  - No gnt or rvalid is produced for the aborted transaction.
  - The aborted master must re-request.
- Addresses DEPTH−1 and 0 are passed through unchanged; the arbiter does no address wrap or check.

## Test plan
- Reset then idle: rst=1 mid-run → all outputs 0 asynchronously. Release with req=0 → FSM stays IDLE, no strobes.
- Single write then read, master 0: write addr0=5, wdata0=8'hA5 → gnt[0] and mem_write one cycle later. Then read addr0=5 → mem_read at +1, rvalid[0] with rdata=8'hA5 at +3, rvalid[1] stays 0.
- Contention after reset: both req=1 in the same cycle → gnt[0] first. Both keep requesting (writes) → gnt sequence 0,1,0,1 over 8 cycles. Each gnt is a single-cycle pulse and gnt is never 2'b11.
- Read routing: master 1 reads addr=31 (preloaded 8'h3C) while master 0 waits with a write → rvalid[1] with rdata=8'h3C. Master 0's write is issued in the cycle after RDONE+IDLE.
- Reset mid-read: assert rst while in RWAIT → no rvalid pulse; prio=0 after release. Master 1 re-requests → served normally.
- Input change after gnt: master 0 changes addr0 and wdata0 in the cycle after gnt[0] → the memory write already issued used the original values (check mem contents).
